// File: rtl/snoop_pkg.sv
// Shared snoop bus types: snoop result encoding, bus op codes, initiator states.
// Used by the bus initiator and the snoop responder models on the same bus.
package snoop_pkg;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10,
        SNP_RSVD  = 2'b11
    } snoop_result_e;

    localparam logic [7:0] OP_READ       = 8'd1;
    localparam logic [7:0] OP_WRITE      = 8'd2;
    localparam logic [7:0] OP_INVALIDATE = 8'd3;
    localparam logic [7:0] OP_RWIM       = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT_SNOOP,
`ifdef HITM_RETRY_EN
        ST_BACKOFF,
`endif
        ST_DONE
    } init_state_e;

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE) ||
               (op == OP_INVALIDATE) || (op == OP_RWIM);
    endfunction

endpackage

// File: rtl/snoop_bus_initiator_bus_driver.sv
// Holds the op/address being issued and drives the shared buses while owned.
// Latency: buses follow own_d one cycle later; no backpressure (pure register + tristate).
// Backpressure: none, the initiator FSM decides ownership.
module bus_driver #(
    parameter int lineSize  = 512,
    parameter int addrWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [7:0]           op,
    input  logic [addrWidth-1:0] addr,
    input  logic                 own_d,
    inout  wire  [lineSize-1:0]  sharedBus,
    inout  wire  [7:0]           sharedOperationBus
);

    logic                 own_q;
    logic [7:0]           op_q;
    logic [addrWidth-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            own_q  <= 1'b0;
            op_q   <= '0;
            addr_q <= '0;
        end else begin
            own_q <= own_d;
            if (load) begin
                op_q   <= op;
                addr_q <= addr;
            end
        end
    end

    // One enable for both buses so they can never be half-owned.
    assign sharedBus          = own_q ? lineSize'(addr_q) : {lineSize{1'bz}};
    assign sharedOperationBus = own_q ? op_q : 8'bz;

endmodule

// File: rtl/snoop_bus_initiator.sv
// L2 bus initiator: issues one op/addr on the shared buses, samples the snoop response, returns result.
// Latency: response pulse snoopLatency+2 cycles after accept; reqReady low while busy, response cannot stall.
// Optional HITM_RETRY_EN: on HITM back off retryDelay cycles and reissue, up to maxRetries times.
module snoop_bus_initiator
    import snoop_pkg::*;
#(
    parameter int lineSize     = 512,
    parameter int addrWidth    = 32,
    parameter int snoopLatency = 2,
    parameter int retryDelay   = 4,
    parameter int maxRetries   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic [7:0]           reqOp,
    input  logic [addrWidth-1:0] reqAddr,
    output logic                 respValid,
    output logic [1:0]           respResult,
    output logic                 respError,
    inout  wire  [lineSize-1:0]  sharedBus,
    inout  wire  [7:0]           sharedOperationBus,
    inout  wire  [1:0]           snoopBus
);

    if (addrWidth > lineSize || snoopLatency < 1 || snoopLatency > 15 ||
        retryDelay < 1 || retryDelay > 15 || maxRetries < 1 || maxRetries > 7) begin : g_param_check
        $error("snoop_bus_initiator: parameter out of legal range");
    end

    init_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    result_q, result_d;
    logic          error_q, error_d;
    logic          accept;
    logic          own_d;
    snoop_result_e snp;
`ifdef HITM_RETRY_EN
    logic [2:0]    retry_q, retry_d;
`endif

    assign accept = reqValid && (state_q == ST_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;
        snp      = snoop_result_e'(snoopBus);
`ifdef HITM_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
`ifdef HITM_RETRY_EN
                    retry_d = '0;
`endif
                    if (op_known(reqOp)) begin
                        state_d = ST_DRIVE;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = SNP_NOHIT;
                        error_d  = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                cnt_d   = 4'(snoopLatency - 1);
                state_d = ST_WAIT_SNOOP;
            end
            ST_WAIT_SNOOP: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    case (snp)
                        SNP_RSVD: begin
                            result_d = SNP_NOHIT;
                            error_d  = 1'b1;
                        end
`ifdef HITM_RETRY_EN
                        SNP_HITM: begin
                            if (retry_q < 3'(maxRetries)) begin
                                state_d = ST_BACKOFF;
                                cnt_d   = 4'(retryDelay - 1);
                                retry_d = retry_q + 3'd1;
                            end else begin
                                result_d = SNP_HITM;
                                error_d  = 1'b0;
                            end
                        end
`endif
                        default: begin
                            result_d = snp;
                            error_d  = 1'b0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef HITM_RETRY_EN
            ST_BACKOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ownership register is loaded from the next state so the buses turn on with DRIVE.
    assign own_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT_SNOOP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
`ifdef HITM_RETRY_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
`ifdef HITM_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    assign reqReady   = (state_q == ST_IDLE);
    assign respValid  = (state_q == ST_DONE);
    assign respResult = result_q;
    assign respError  = error_q;

    bus_driver #(
        .lineSize  (lineSize),
        .addrWidth (addrWidth)
    ) u_drv (
        .clk                (clk),
        .reset              (reset),
        .load               (accept),
        .op                 (reqOp),
        .addr               (reqAddr),
        .own_d              (own_d),
        .sharedBus          (sharedBus),
        .sharedOperationBus (sharedOperationBus)
    );

endmodule

// File: tb/tb_snoop_bus_initiator.sv
// Directed bench for snoop_bus_initiator: vector table of single transactions plus
// hand sequences for reset abort, back-to-back spacing and (with HITM_RETRY_EN) backoff.
module tb_snoop_bus_initiator;

    localparam int L  = 2;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [7:0]  reqOp;
    logic [31:0] reqAddr;
    logic        respValid;
    logic [1:0]  respResult;
    logic        respError;
    logic [1:0]  snoop_drv;
    wire  [511:0] sharedBus;
    wire  [7:0]   sharedOperationBus;
    wire  [1:0]   snoopBus;

    assign snoopBus = snoop_drv;

    always #5 clk = ~clk;

    snoop_bus_initiator #(
        .lineSize     (512),
        .addrWidth    (32),
        .snoopLatency (L),
        .retryDelay   (RD),
        .maxRetries   (3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .reqValid           (reqValid),
        .reqReady           (reqReady),
        .reqOp              (reqOp),
        .reqAddr            (reqAddr),
        .respValid          (respValid),
        .respResult         (respResult),
        .respError          (respError),
        .sharedBus          (sharedBus),
        .sharedOperationBus (sharedOperationBus),
        .snoopBus           (snoopBus)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [1:0]  snoop;
        logic [1:0]  res;
        logic        err;
        logic        bus;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic owned();
        return dut.u_drv.own_q;
    endfunction

    // One transaction; accept at the posedge following the request negedge (edge 0).
    task automatic run_txn(input vec_t v);
        int last;
        @(negedge clk);
        chk("ready_before", 64'(reqReady), 64'd1);
        reqValid  = 1'b1;
        reqOp     = v.op;
        reqAddr   = v.addr;
        snoop_drv = v.snoop;
        @(posedge clk);
        #1 reqValid = 1'b0;
        last = v.bus ? 2 + L : 1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            chk($sformatf("own_c%0d", c), 64'(owned()), 64'(v.bus && (c <= 1 + L)));
            if (v.bus && (c <= 1 + L)) begin
                chk("op_bus", 64'(sharedOperationBus), 64'(v.op));
                chk("addr_bus", 64'(sharedBus[31:0]), 64'(v.addr));
                chk("addr_hi_zero", 64'(|sharedBus[511:32]), 64'd0);
            end
            chk($sformatf("valid_c%0d", c), 64'(respValid), 64'(c == last));
            chk("ready_busy", 64'(reqReady), 64'd0);
            if (c == last) begin
                chk("result", 64'(respResult), 64'(v.res));
                chk("error", 64'(respError), 64'(v.err));
            end
        end
        @(negedge clk);
        chk("valid_after", 64'(respValid), 64'd0);
        chk("ready_after", 64'(reqReady), 64'd1);
        chk("result_hold", 64'(respResult), 64'(v.res));
        chk("error_hold", 64'(respError), 64'(v.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int second;
        logic acc;

        tbl.push_back('{op: 8'h01, addr: 32'h0000_1000, snoop: 2'b00, res: 2'b00, err: 1'b0, bus: 1'b1});
        tbl.push_back('{op: 8'h01, addr: 32'h0000_0002, snoop: 2'b01, res: 2'b01, err: 1'b0, bus: 1'b1});
`ifndef HITM_RETRY_EN
        tbl.push_back('{op: 8'h04, addr: 32'h0000_000C, snoop: 2'b10, res: 2'b10, err: 1'b0, bus: 1'b1});
`endif
        tbl.push_back('{op: 8'h02, addr: 32'hFFFF_FFFF, snoop: 2'b11, res: 2'b00, err: 1'b1, bus: 1'b1});
        tbl.push_back('{op: 8'h07, addr: 32'h0000_0040, snoop: 2'b00, res: 2'b00, err: 1'b1, bus: 1'b0});
        tbl.push_back('{op: 8'h03, addr: 32'h8000_0000, snoop: 2'b01, res: 2'b01, err: 1'b0, bus: 1'b1});
        tbl.push_back('{op: 8'h00, addr: 32'h0000_0010, snoop: 2'b01, res: 2'b00, err: 1'b1, bus: 1'b0});

        reset     = 1'b1;
        reqValid  = 1'b0;
        reqOp     = '0;
        reqAddr   = '0;
        snoop_drv = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(reqReady), 64'd1);
        chk("rst_valid", 64'(respValid), 64'd0);
        chk("rst_result", 64'(respResult), 64'd0);
        chk("rst_error", 64'(respError), 64'd0);
        chk("rst_own", 64'(owned()), 64'd0);
        reset = 1'b0;

        foreach (tbl[i]) run_txn(tbl[i]);

`ifdef HITM_RETRY_EN
        // HITM on first issue, then NOHIT: buses owned cycles 1-3 and 8-10, response in cycle 11.
        @(negedge clk);
        reqValid  = 1'b1;
        reqOp     = 8'h04;
        reqAddr   = 32'h0000_000C;
        snoop_drv = 2'b10;
        @(posedge clk);
        #1 reqValid = 1'b0;
        for (int c = 1; c <= 3 + L + RD + L + 1; c++) begin
            @(negedge clk);
            if (c == 2 + L) snoop_drv = 2'b00;
            chk($sformatf("retry_own_c%0d", c), 64'(owned()),
                64'((c <= 1 + L) || ((c >= 2 + L + RD) && (c <= 2 + 2 * L + RD))));
            chk($sformatf("retry_valid_c%0d", c), 64'(respValid), 64'(c == 3 + 2 * L + RD));
        end
        chk("retry_result", 64'(respResult), 64'd0);
        chk("retry_error", 64'(respError), 64'd0);
        @(negedge clk);
`endif

        // Reset during the second WAIT_SNOOP cycle aborts without a response.
        @(negedge clk);
        reqValid  = 1'b1;
        reqOp     = 8'h01;
        reqAddr   = 32'h0000_0100;
        snoop_drv = 2'b01;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_own_before", 64'(owned()), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_own", 64'(owned()), 64'd0);
            chk("abort_valid", 64'(respValid), 64'd0);
            chk("abort_ready", 64'(reqReady), 64'd1);
        end

        // reqValid held high: accepts spaced exactly L+3 cycles.
        first  = -1;
        second = -1;
        @(negedge clk);
        reqValid  = 1'b1;
        reqOp     = 8'h01;
        reqAddr   = 32'h0000_0020;
        snoop_drv = 2'b00;
        for (int i = 0; i < 40; i++) begin
            acc = reqReady;
            @(posedge clk);
            if (acc) begin
                if (first < 0) first = i;
                else begin
                    second = i;
                    break;
                end
            end
            @(negedge clk);
        end
        #1 reqValid = 1'b0;
        chk("b2b_spacing", 64'(second - first), 64'(L + 3));
        repeat (L + 4) @(negedge clk);
        chk("b2b_ready_end", 64'(reqReady), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
